// File: rtl/serial_fifo_ctrl.sv
// serial_fifo_ctrl: bus-facing UART controller with RX/TX FIFOs, a small
// STATUS/CTRL register map, sticky overrun/overflow flags and a level
// interrupt. Optional internal loopback path is built when the macro
// SERIAL_LOOPBACK_EN is defined; without it CTRL[2] is read-as-zero.
module serial_fifo_ctrl #(
  parameter int DEPTH_LOG2    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int RX_INT_THRESH = 1,
  parameter int BUSY_TIMEOUT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  readEnable_i,
  input  logic [1:0]            addr_i,
  input  logic [31:0]           dataSave_i,
  output logic [31:0]           dataLoad_o,
  output logic                  int_o,
  input  logic                  rxdReady_i,
  input  logic [DATA_WIDTH-1:0] rxdData_i,
  input  logic                  txdBusy_i,
  output logic                  txdStart_o,
  output logic [DATA_WIDTH-1:0] txdData_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_CNT     = CW'(DEPTH);
  localparam logic [CW-1:0] RX_THRESH    = CW'(RX_INT_THRESH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  // Bus access decode
  logic enable_q;
  logic strb;
  logic rd_strb;
  logic wr_strb;
  logic data_rd;
  logic data_wr;
  logic status_wr;
  logic ctrl_wr;

  // Control register bits
  logic rx_ie;
  logic txe_ie;
  logic loopback;

  // RX FIFO
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr;
  logic [CW-1:0]         rx_count;
  logic                  rx_empty;
  logic                  rx_full;
  logic                  rx_pop;
  logic                  rx_push_req;
  logic                  rx_push;
  logic [DATA_WIDTH-1:0] rx_push_data;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  rx_overrun;
  logic                  rx_ovr_set;

  // TX FIFO
  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr;
  logic [CW-1:0]         tx_count;
  logic                  tx_empty;
  logic                  tx_full;
  logic                  tx_pop;
  logic                  tx_push_req;
  logic                  tx_push;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_overflow;
  logic                  tx_ovf_set;
  logic                  tx_idle;

  // Transmit sequencer
  tx_state_t     state;
  tx_state_t     state_next;
  logic [TW-1:0] tmo_cnt;
  logic          send_now;

  // Loopback path
  logic lb_push;
  logic lb_drop;

  logic [31:0] status_word;
  logic        unused_data;

  // Upper write-data bits beyond the character width carry no meaning
  assign unused_data = ^dataSave_i[31:DATA_WIDTH];

  assign strb      = enable_i & ~enable_q;
  assign rd_strb   = strb & readEnable_i;
  assign wr_strb   = strb & ~readEnable_i;
  assign data_rd   = rd_strb & (addr_i == ADDR_DATA);
  assign data_wr   = wr_strb & (addr_i == ADDR_DATA);
  assign status_wr = wr_strb & (addr_i == ADDR_STATUS);
  assign ctrl_wr   = wr_strb & (addr_i == ADDR_CTRL);

  // Edge-detect the device select so a held enable is a single access
  always_ff @(posedge clk) begin
    if (rst) enable_q <= 1'b0;
    else     enable_q <= enable_i;
  end

  // Interrupt enables; RX interrupt is on out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ie  <= 1'b1;
      txe_ie <= 1'b0;
    end else if (ctrl_wr) begin
      rx_ie  <= dataSave_i[0];
      txe_ie <= dataSave_i[1];
    end
  end

`ifdef SERIAL_LOOPBACK_EN
  // Loopback select bit
  always_ff @(posedge clk) begin
    if (rst)          loopback <= 1'b0;
    else if (ctrl_wr) loopback <= dataSave_i[2];
  end

  // In loopback the sequencer feeds RX instead of the transmitter; an
  // external character arriving in the same cycle takes the slot.
  assign lb_push = (state == START) & loopback;
  assign lb_drop = lb_push & rxdReady_i;
`else
  assign loopback = 1'b0;
  assign lb_push  = 1'b0;
  assign lb_drop  = 1'b0;
`endif

  // ---------------- RX FIFO ----------------
  assign rx_empty     = (rx_count == '0);
  assign rx_full      = (rx_count == FULL_CNT);
  assign rx_head      = rx_mem[rx_rd_ptr];
  assign rx_pop       = data_rd & ~rx_empty;
  assign rx_push_req  = rxdReady_i | lb_push;
  assign rx_push_data = rxdReady_i ? rxdData_i : tx_head;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign rx_push      = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovr_set   = (rx_push_req & rx_full & ~rx_pop) | lb_drop;

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
  end

  // RX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky RX overrun; a new event wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                             rx_overrun <= 1'b0;
    else if (rx_ovr_set)                 rx_overrun <= 1'b1;
    else if (status_wr && dataSave_i[2]) rx_overrun <= 1'b0;
  end

  // ---------------- TX FIFO ----------------
  assign tx_empty    = (tx_count == '0);
  assign tx_full     = (tx_count == FULL_CNT);
  assign tx_head     = tx_mem[tx_rd_ptr];
  assign tx_pop      = (state == START);
  assign tx_push_req = data_wr;
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;
  assign tx_idle     = tx_empty & (state == IDLE);

  // TX storage write
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= dataSave_i[DATA_WIDTH-1:0];
  end

  // TX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Sticky TX overflow; a new event wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                             tx_overflow <= 1'b0;
    else if (tx_ovf_set)                 tx_overflow <= 1'b1;
    else if (status_wr && dataSave_i[3]) tx_overflow <= 1'b0;
  end

  // ---------------- Transmit sequencer ----------------
  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: one character in flight, wait for busy to rise
  // (or give up after the timeout) and then fall before the next one
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!tx_empty && !txdBusy_i) state_next = START;
      end
      START: begin
        state_next = loopback ? IDLE : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (txdBusy_i || (tmo_cnt == TIMEOUT_LAST)) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!txdBusy_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cycles spent waiting for the transmitter to acknowledge
  always_ff @(posedge clk) begin
    if (rst || (state != WAIT_BUSY)) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign send_now = (state == START) & ~loopback;

  // Start pulse and character register; data stays put until the next start
  always_ff @(posedge clk) begin
    if (rst) begin
      txdStart_o <= 1'b0;
      txdData_o  <= '0;
    end else begin
      txdStart_o <= send_now;
      if (send_now) txdData_o <= tx_head;
    end
  end

  // ---------------- Register read and interrupt ----------------
  assign status_word = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000,
                        tx_idle, tx_overflow, rx_overrun, ~tx_full, ~rx_empty};

  // Read mux, valid whenever the device is selected
  always_comb begin
    dataLoad_o = '0;
    if (enable_i) begin
      case (addr_i)
        ADDR_DATA:   if (!rx_empty) dataLoad_o = {{(32-DATA_WIDTH){1'b0}}, rx_head};
        ADDR_STATUS: dataLoad_o = status_word;
        ADDR_CTRL:   dataLoad_o = {29'b0, loopback, txe_ie, rx_ie};
        default:     dataLoad_o = '0;
      endcase
    end
  end

  // Registered level interrupt request
  always_ff @(posedge clk) begin
    if (rst) int_o <= 1'b0;
    else     int_o <= (rx_ie & ((rx_count >= RX_THRESH) | rx_overrun)) |
                      (txe_ie & tx_idle);
  end

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Directed scoreboard bench for serial_fifo_ctrl. RX characters and TX
// writes are queued as they are driven and compared when read back over the
// bus or when the transmitter start pulse appears. A simple transmitter
// model raises busy for five cycles starting one cycle after each start.
module tb_serial_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        readEnable_i;
  logic [1:0]  addr_i;
  logic [31:0] dataSave_i;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic        rxdReady_i;
  logic [7:0]  rxdData_i;
  logic        txdBusy_i = 1'b0;
  logic        txdStart_o;
  logic [7:0]  txdData_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_sb[$];
  logic [7:0] tx_sb[$];
  int  tx_sent    = 0;
  int  busy_cnt   = 0;
  bit  busy_force = 1'b0;
  bit  mon_en     = 1'b0;
  bit  m_rx_ovr   = 1'b0;
  bit  m_tx_ovf   = 1'b0;
  logic busy_now;

  serial_fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .readEnable_i (readEnable_i),
    .addr_i       (addr_i),
    .dataSave_i   (dataSave_i),
    .dataLoad_o   (dataLoad_o),
    .int_o        (int_o),
    .rxdReady_i   (rxdReady_i),
    .rxdData_i    (rxdData_i),
    .txdBusy_i    (txdBusy_i),
    .txdStart_o   (txdStart_o),
    .txdData_o    (txdData_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int txc, input bit txidle);
    int rxc;
    rxc = rx_sb.size();
    return {8'h00, 8'(txc), 8'(rxc), 3'b000, txidle, m_tx_ovf, m_rx_ovr,
            (txc < 16), (rxc > 0)};
  endfunction

  // Transmitter model and start-pulse monitor
  always @(negedge clk) begin
    busy_now = txdBusy_i;
    if (mon_en && txdStart_o === 1'b1) begin
      check("start_vs_busy", 32'(busy_now), 32'd0);
      checks++;
      assert (tx_sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_start observed=0x%0h expected=no_start", txdData_o);
      end
      if (tx_sb.size() > 0) check("tx_data", 32'(txdData_o), 32'(tx_sb.pop_front()));
      tx_sent++;
    end
    if (busy_force) txdBusy_i = 1'b1;
    else if (busy_cnt > 0) begin
      txdBusy_i = 1'b1;
      busy_cnt--;
    end else txdBusy_i = 1'b0;
    if (txdStart_o === 1'b1) busy_cnt = 5;
  end

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    enable_i = 1'b1; readEnable_i = 1'b1; addr_i = a;
    #1 d = dataLoad_o;
    @(negedge clk);
    enable_i = 1'b0; readEnable_i = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    enable_i = 1'b1; readEnable_i = 1'b0; addr_i = a; dataSave_i = v;
    @(negedge clk);
    enable_i = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] v);
    @(negedge clk);
    rxdReady_i = 1'b1; rxdData_i = v;
    @(negedge clk);
    rxdReady_i = 1'b0;
    if (rx_sb.size() < 16) rx_sb.push_back(v);
    else m_rx_ovr = 1'b1;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    bus_read(2'd0, d);
    e = (rx_sb.size() > 0) ? 32'(rx_sb.pop_front()) : 32'd0;
    check(tag, d, e);
  endtask

  // DATA read coinciding with an external receive pulse
  task automatic read_with_rx(input logic [7:0] v, input string tag);
    logic [31:0] d;
    logic [31:0] e;
    @(negedge clk);
    enable_i = 1'b1; readEnable_i = 1'b1; addr_i = 2'd0;
    rxdReady_i = 1'b1; rxdData_i = v;
    #1 d = dataLoad_o;
    @(negedge clk);
    enable_i = 1'b0; readEnable_i = 1'b0; rxdReady_i = 1'b0;
    e = 32'(rx_sb.pop_front());
    rx_sb.push_back(v);
    check(tag, d, e);
  endtask

  initial begin
    logic [31:0] d;
    int sent_before;
    rst = 1'b1; enable_i = 1'b0; readEnable_i = 1'b0; addr_i = 2'd0;
    dataSave_i = 32'd0; rxdReady_i = 1'b0; rxdData_i = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_start", 32'(txdStart_o), 32'd0);
    check("reset_txdata", 32'(txdData_o), 32'd0);
    check("reset_int", 32'(int_o), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    bus_read(2'd1, d); check("reset_status", d, exp_status(0, 1'b1));
    bus_read(2'd2, d); check("reset_ctrl", d, 32'h1);

    // Three received characters, read back in order
    rx_pulse(8'h41); rx_pulse(8'h42); rx_pulse(8'h43);
    bus_read(2'd1, d);
    check("t1_status", d, exp_status(0, 1'b1));
    check("t1_rx_count", 32'(d[15:8]), 32'd3);
    check("t1_int", 32'(int_o), 32'd1);
    read_data("t1_rd0"); read_data("t1_rd1"); read_data("t1_rd2");
    check("t1_int_hold", 32'(int_o), 32'd1);
    @(negedge clk);
    check("t1_int_fall", 32'(int_o), 32'd0);
    read_data("t1_rd_empty");

    // Two transmitted characters with the busy model
    bus_write(2'd0, 32'h55); tx_sb.push_back(8'h55);
    bus_write(2'd0, 32'hAA); tx_sb.push_back(8'hAA);
    for (int i = 0; i < 300 && tx_sb.size() > 0; i++) @(negedge clk);
    check("t3_drained", 32'(tx_sb.size()), 32'd0);
    check("t3_sent", 32'(tx_sent), 32'd2);
    repeat (10) @(negedge clk);
    check("t3_data_held", 32'(txdData_o), 32'hAA);
    bus_read(2'd1, d);
    check("t3_tx_idle", 32'(d[4]), 32'd1);
    check("t3_status", d, exp_status(0, 1'b1));

    // TX-empty interrupt source
    bus_write(2'd2, 32'h2);
    @(negedge clk);
    check("txe_int_on", 32'(int_o), 32'd1);
    bus_write(2'd2, 32'h1);
    @(negedge clk);
    check("txe_int_off", 32'(int_o), 32'd0);

    // TX overflow with the transmitter held busy
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      bus_write(2'd0, 32'(8'h10 + 8'(i)));
      if (i < 16) tx_sb.push_back(8'h10 + 8'(i));
      else m_tx_ovf = 1'b1;
    end
    bus_read(2'd1, d);
    check("t4_tx_count", 32'(d[23:16]), 32'd16);
    check("t4_overflow", 32'(d[3]), 32'd1);
    check("t4_status", d, exp_status(16, 1'b0));
    check("t4_no_send", 32'(tx_sent), 32'd2);
    busy_force = 1'b0;
    for (int i = 0; i < 3000 && tx_sb.size() > 0; i++) @(negedge clk);
    check("t4_drained", 32'(tx_sb.size()), 32'd0);
    check("t4_sent", 32'(tx_sent), 32'd18);
    repeat (10) @(negedge clk);
    bus_write(2'd1, 32'h8); m_tx_ovf = 1'b0;
    bus_read(2'd1, d);
    check("t4_status_clr", d, exp_status(0, 1'b1));

    // RX overrun and write-1-to-clear
    for (int i = 0; i < 17; i++) rx_pulse(8'h60 + 8'(i));
    bus_read(2'd1, d);
    check("t2_rx_count", 32'(d[15:8]), 32'd16);
    check("t2_overrun", 32'(d[2]), 32'd1);
    check("t2_status", d, exp_status(0, 1'b1));
    bus_write(2'd1, 32'h4); m_rx_ovr = 1'b0;
    bus_read(2'd1, d);
    check("t2_status_clr", d, exp_status(0, 1'b1));

    // Simultaneous pop and push while full, across pointer wrap
    for (int i = 0; i < 3; i++) read_with_rx(8'h90 + 8'(i), "t5_rd_push");
    bus_read(2'd1, d);
    check("t5_status", d, exp_status(0, 1'b1));
    for (int i = 0; i < 16; i++) read_data("t5_drain");
    bus_read(2'd1, d);
    check("t5_status_empty", d, exp_status(0, 1'b1));

`ifdef SERIAL_LOOPBACK_EN
    bus_write(2'd2, 32'h5);
    bus_read(2'd2, d); check("t6_ctrl_lb", d, 32'h5);
    sent_before = tx_sent;
    bus_write(2'd0, 32'h3C); rx_sb.push_back(8'h3C);
    repeat (10) @(negedge clk);
    check("t6_no_start", 32'(tx_sent), 32'(sent_before));
    read_data("t6_loop_data");
    bus_write(2'd2, 32'h1);
`else
    sent_before = tx_sent;
    bus_write(2'd2, 32'h5);
    bus_read(2'd2, d); check("t6_ctrl_no_lb", d, 32'h1);
    check("t6_no_start", 32'(tx_sent), 32'(sent_before));
`endif

    // Unmapped address
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d); check("addr3_read", d, 32'd0);
    bus_read(2'd1, d); check("final_status", d, exp_status(0, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
